// File: rtl/data_mem_port.sv
// Load/store data-memory responder: word RAM split into four big-endian byte lanes,
// fixed wait-state latency, left-justified load data and alignment rejection.

module data_mem_lane #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [7:0]    wbyte,
    output logic [7:0]    rbyte
);
    logic [7:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk)
        if (we) mem[idx] <= wbyte;

    assign rbyte = mem[idx];
endmodule

module data_mem_port #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic            isStore,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            req_ready,
    output logic            resp_valid,
    output logic [31:0]     memData,
    output logic            misaligned,
    output logic            stall
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic          is_store;
        logic [1:0]    size;
        logic [AW-1:0] idx;
        logic [1:0]    off;
        logic [31:0]   wdata;
    } req_t;

    state_t      state, nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        enter_resp;
    logic        mis_q;
    req_t        req_in, req_q, cur;
    logic        legal;
    logic [2:0]  nbytes;
    logic [1:0]  wshift;
    logic [31:0] wword, rword;
    logic [3:0]  be;
    logic        we_en;
    logic        unused_bits;

    always_comb begin
        req_in          = '0;
        req_in.is_store = isStore;
        req_in.size     = funct3[1:0];
        req_in.idx      = addr[AW+1:2];
        req_in.off      = addr[1:0];
        req_in.wdata    = wdata[31:0];
    end

    // With zero wait states the access happens on the accepting edge, before req_q is loaded.
    assign cur = (state == IDLE) ? req_in : req_q;

    always_comb begin
        legal  = 1'b0;
        nbytes = 3'd0;
        case (cur.size)
            2'b00: begin legal = 1'b1;             nbytes = 3'd1; end
            2'b01: begin legal = ~cur.off[0];      nbytes = 3'd2; end
            2'b10: begin legal = (cur.off == 2'd0); nbytes = 3'd4; end
            default: begin legal = 1'b0;           nbytes = 3'd0; end
        endcase
    end

    // Move the right-justified store bytes up so the last one lands on lane off+nbytes-1.
    assign wshift = 2'(3'd4 - nbytes - {1'b0, cur.off});
    assign wword  = cur.wdata << {wshift, 3'b000};
    assign we_en  = enter_resp & cur.is_store & legal & ~reset;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign be[i] = (3'(i) >= {1'b0, cur.off}) && (3'(i) < ({1'b0, cur.off} + nbytes));
        data_mem_lane #(.AW(AW)) u_lane (
            .clk  (clk),
            .we   (we_en & be[i]),
            .idx  (cur.idx),
            .wbyte(wword[8*(3-i) +: 8]),
            .rbyte(rword[8*(3-i) +: 8])
        );
    end

    always_comb begin
        nxt        = state;
        cnt_nxt    = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE: if (req_valid) begin
                if (WAIT_STATES == 0) begin
                    nxt        = RESP;
                    enter_resp = 1'b1;
                end else begin
                    nxt     = WAIT;
                    cnt_nxt = CNT_INIT;
                end
            end
            WAIT: if (cnt == 4'd0) begin
                nxt        = RESP;
                enter_resp = 1'b1;
            end else begin
                cnt_nxt = cnt - 4'd1;
            end
            RESP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            mis_q   <= 1'b0;
            memData <= 32'd0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && req_valid) req_q <= req_in;
            if (enter_resp) begin
                mis_q <= ~legal;
                if (!legal)             memData <= 32'd0;
                else if (!cur.is_store) memData <= rword << {cur.off, 3'b000};
            end
        end
    end

    assign req_ready   = (state == IDLE);
    assign resp_valid  = (state == RESP);
    assign misaligned  = resp_valid & mis_q;
    assign stall       = ((state == IDLE) & req_valid) | (state == WAIT);
    assign unused_bits = ^{funct3[2], addr, wdata};
endmodule

// File: tb/tb_data_mem_port.sv
// Randomized and directed checks of data_mem_port against a byte-array memory model.

module tb_data_mem_port;
    localparam int XLEN = 32, DEPTH = 1024, WS = 1, NB = DEPTH * 4;

    logic        clk = 1'b0, reset, req_valid, isStore;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        req_ready, resp_valid, misaligned, stall;
    logic [31:0] memData;

    data_mem_port #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .isStore(isStore),
        .funct3(funct3), .addr(addr), .wdata(wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .memData(memData), .misaligned(misaligned), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          acc;
        bit          st;
        logic [31:0] data;
        logic        mis;
    } exp_t;

    int          n_chk = 0, n_fail = 0, cyc = 0, resp_cnt = 0;
    bit          chk_en = 0;
    logic [7:0]  mb [NB];
    logic [31:0] last_data = '0;
    logic        last_mis = 1'b0;
    exp_t        q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit legal_f(logic [1:0] sz, int off);
        return (sz == 2'd0) || (sz == 2'd1 && off % 2 == 0) || (sz == 2'd2 && off == 0);
    endfunction

    // Byte-addressed reference: stores scatter bytes, loads return the word shifted left by offset.
    task automatic model(bit st, logic [2:0] f3, logic [31:0] a, logic [31:0] wd, output exp_t e);
        int base, off;
        logic [31:0] v;
        base  = int'(a % NB) & ~3;
        off   = int'(a % 4);
        e.acc = cyc;
        e.st  = st;
        e.mis = !legal_f(f3[1:0], off);
        e.data = '0;
        if (e.mis) return;
        if (st) begin
            case (f3[1:0])
                2'd0: mb[base+off] = wd[7:0];
                2'd1: begin mb[base+off] = wd[15:8]; mb[base+off+1] = wd[7:0]; end
                default: for (int j = 0; j < 4; j++) mb[base+j] = wd[31-8*j -: 8];
            endcase
        end else begin
            v = '0;
            for (int j = 0; j < 4 - off; j++) v[31-8*j -: 8] = mb[base+off+j];
            e.data = v;
        end
    endtask

    always @(negedge clk) begin
        bit out, rsp;
        int a;
        logic [31:0] d;
        if (chk_en) begin
            out = (q.size() > 0);
            a   = out ? q[0].acc : 0;
            rsp = out && (cyc == a + 1 + WS);
            check("resp_valid", resp_valid, rsp);
            check("stall", stall, out && cyc >= a && cyc <= a + WS);
            check("req_ready", req_ready, !(out && cyc > a));
            if (rsp) begin
                d = (q[0].st && !q[0].mis) ? last_data : q[0].data;
                check("memData", memData, d);
                check("misaligned", misaligned, q[0].mis);
                last_data = d;
                last_mis  = misaligned;
                void'(q.pop_front());
                resp_cnt++;
            end else begin
                check("memData_hold", memData, last_data);
                check("misaligned_idle", misaligned, 0);
            end
        end
    end

    task automatic req(bit st, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
        exp_t e;
        int   n;
        model(st, f3, a, wd, e);
        q.push_back(e);
        n = resp_cnt;
        isStore = st; funct3 = f3; addr = a; wdata = wd; req_valid = 1'b1;
        @(posedge clk); #1;
        // Garbage on the inputs while busy must be ignored.
        for (int k = 0; k < 40 && resp_cnt == n; k++) begin
            req_valid = 1'($urandom_range(0, 1));
            isStore = 1'($urandom_range(0, 1));
            funct3 = 3'($urandom_range(0, 7));
            addr = $urandom; wdata = $urandom;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        check("response_count", resp_cnt, n + 1);
        if (resp_cnt != n + 1) q.delete();
    endtask

    task automatic reset_in_wait();
        chk_en = 0;
        isStore = 1'b1; funct3 = 3'b010; addr = 32'h30; wdata = 32'hFFFF_FFFF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("stall_wait", stall, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_resp_valid", resp_valid, 0);
        check("rst_misaligned", misaligned, 0);
        check("rst_memData", memData, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_stall", stall, 0);
        repeat (3) begin
            @(posedge clk); #1;
            check("no_resp_after_rst", resp_valid, 0);
        end
        last_data = '0;
        chk_en = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        reset = 1'b1; req_valid = 1'b0; isStore = 1'b0; funct3 = '0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("init_resp_valid", resp_valid, 0);
        check("init_misaligned", misaligned, 0);
        check("init_memData", memData, 0);
        check("init_req_ready", req_ready, 1);
        check("init_stall", stall, 0);
        chk_en = 1;

        req(1, 3'b010, 32'h10, 32'h1122_3344);
        req(0, 3'b010, 32'h10, 32'h0);        check("lw_10", memData, 32'h1122_3344);
        req(0, 3'b000, 32'h13, 32'h0);        check("lb_13", memData, 32'h4400_0000);
        req(0, 3'b001, 32'h12, 32'h0);        check("lh_12", memData, 32'h3344_0000);
        req(1, 3'b000, 32'h11, 32'h0000_00AB);
        req(0, 3'b010, 32'h10, 32'h0);        check("sb_lw_10", memData, 32'h11AB_3344);
        req(1, 3'b010, 32'h20, 32'h0);
        req(1, 3'b001, 32'h22, 32'h0000_BEEF);
        req(0, 3'b010, 32'h20, 32'h0);        check("sh_lw_20", memData, 32'h0000_BEEF);
        req(0, 3'b010, 32'h11, 32'h0);        check("lw_11_data", memData, 0);
        check("lw_11_mis", last_mis, 1);
        req(1, 3'b001, 32'h13, 32'h5555);     check("sh_13_mis", last_mis, 1);
        req(1, 3'b011, 32'h10, 32'hDEAD_BEEF); check("sz3_mis", last_mis, 1);
        req(0, 3'b010, 32'h10, 32'h0);        check("unchanged_10", memData, 32'h11AB_3344);
        req(1, 3'b010, NB + 4, 32'hCAFE_F00D);
        req(0, 3'b010, 32'h4, 32'h0);         check("wrap_4", memData, 32'hCAFE_F00D);
        req(1, 3'b010, 32'h30, 32'h1);
        reset_in_wait();
        req(0, 3'b010, 32'h30, 32'h0);        check("after_rst_30", memData, 32'h1);

        for (int w = 0; w < 16; w++) req(1, 3'b010, 32'(w * 4), $urandom);
        for (int i = 0; i < 200; i++) begin
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_F000);
            req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end

        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
